vx_om_req_arb: RTL

//  Round-robin arbiter sharing one OM unit request port among NUM_REQS requesters (per-core om_bus

---
 rtl/vx_om_req_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vx_om_req_arb.sv
// Round-robin arbiter that shares one OM unit request port among NUM_REQS
// requesters. Each granted request goes into a 2-entry elastic output buffer.
// Requests whose lane mask is all zeros are accepted but never forwarded.
// While drain_req is high, no new requests are granted, and drain_ack reports
// when the buffer has emptied.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   in_valid/in_data    per-requester request and packed payload (P bits each)
//   in_ready            per-requester accept, only for the granted requester
//   out_valid/out_data  buffered request to the OM unit; out_src gives its requester
//   out_ready           OM unit accept
//   drain_req/drain_ack drain handshake used before DCR reconfiguration
//   perf_stall_cycles   count of cycles with a pending request but no grant
module vx_om_req_arb #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned UUID_W     = 44,
    parameter int unsigned DIM_BITS   = 11,
    parameter int unsigned DEPTH_BITS = 24,
    parameter int unsigned COLOR_BITS = 32,
    localparam int unsigned IDX_W     = $clog2(NUM_REQS),
    localparam int unsigned P         = UUID_W + NUM_LANES * (1 + 2 * DIM_BITS + COLOR_BITS + DEPTH_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQS-1:0]   in_valid,
    input  logic [NUM_REQS*P-1:0] in_data,
    output logic [NUM_REQS-1:0]   in_ready,
    output logic                  out_valid,
    output logic [P-1:0]          out_data,
    output logic [IDX_W-1:0]      out_src,
    input  logic                  out_ready,
    input  logic                  drain_req,
    output logic                  drain_ack,
    output logic [31:0]           perf_stall_cycles
);

    // The uuid occupies the top of the payload, and the lane mask sits directly below it.
    localparam int unsigned MASK_LSB = P - UUID_W - NUM_LANES;

    logic [IDX_W-1:0] rr_ptr;
    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [P-1:0]     buf_data [2];
    logic [IDX_W-1:0] buf_src  [2];

    logic             pop;
    logic             push;
    logic             fire;
    logic             can_accept;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [P-1:0]     grant_data;

    // Head of the buffer; driven only from registers.
    assign out_valid = (count != 2'd0);
    assign out_data  = buf_data[rd_ptr];
    assign out_src   = buf_src[rd_ptr];

    assign pop        = out_valid && out_ready;
    assign can_accept = reset && !drain_req && ((count != 2'd2) || pop);
    assign fire       = grant_found && can_accept;
    assign push       = fire && (grant_data[MASK_LSB +: NUM_LANES] != '0);
    assign drain_ack  = reset && drain_req && (count == 2'd0);

    // Find the first valid requester, starting at rr_ptr and wrapping around.
    always_comb begin : grant_search
        logic [IDX_W-1:0] idx;
        idx         = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQS);
            if (!grant_found && in_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Select the granted payload and drive in_ready for the granted requester.
    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                grant_data  = in_data[i*P +: P];
                in_ready[i] = fire;
            end
        end
    end

    // Round-robin pointer, 2-entry FIFO and stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr            <= '0;
            count             <= 2'd0;
            rd_ptr            <= 1'b0;
            wr_ptr            <= 1'b0;
            buf_data[0]       <= '0;
            buf_data[1]       <= '0;
            buf_src[0]        <= '0;
            buf_src[1]        <= '0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (fire) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
            // When the buffer is full and a pop happens in the same cycle, the write reuses the slot being popped.
            if (push) begin
                buf_data[wr_ptr] <= grant_data;
                buf_src[wr_ptr]  <= grant_idx;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if ((in_valid != '0) && !fire) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end

endmodule
